// File: rtl/fetch_sequencer.sv
// Instruction fetch sequencer: variable-length fetch over a
// req/ack program-memory port, fields held stable through execute.
module fetch_sequencer #(
  parameter int ADDR_W    = 12,
  parameter int BYTE_W    = 8,
  parameter int OPC_W     = 4,
  parameter int MAX_EXT   = 2,
  parameter int EXT_LEN_W = 2
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      run,
  output logic [ADDR_W-1:0]         mem_addr,
  output logic                      mem_req,
  input  logic                      mem_ack,
  input  logic [BYTE_W-1:0]         mem_data,
  output logic [OPC_W-1:0]          instr,
  output logic [BYTE_W-OPC_W-1:0]   operand,
  output logic [MAX_EXT*BYTE_W-1:0] ext_data,
  input  logic [EXT_LEN_W-1:0]      ext_len,
  output logic                      phase,
  output logic                      instr_valid,
  input  logic                      exec_done,
  input  logic                      load_pc,
  input  logic [ADDR_W-1:0]         new_addr,
  output logic [ADDR_W-1:0]         pc,
  output logic                      len_err
);

  localparam int OPR_W = BYTE_W - OPC_W;
  localparam logic [EXT_LEN_W-1:0] MAX_EXT_C =
    EXT_LEN_W'(MAX_EXT);
  localparam logic [EXT_LEN_W-1:0] ONE_C =
    EXT_LEN_W'(1);

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    DECODE,
    FETCH_EXT,
    EXEC
  } state_t;

  state_t               state;
  state_t               state_nxt;
  logic [EXT_LEN_W-1:0] cnt;
  logic [EXT_LEN_W-1:0] k;
  logic [EXT_LEN_W-1:0] len_eff;
  logic                 len_over;

  // Clamp the decoded extension length to what the buffer can hold.
  always_comb begin
    len_over = ext_len > MAX_EXT_C;
    len_eff  = len_over ? MAX_EXT_C : ext_len;
  end

  // State register; reset abandons any outstanding request.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state and memory/phase outputs.
  always_comb begin
    state_nxt   = state;
    mem_req     = 1'b0;
    phase       = 1'b0;
    instr_valid = 1'b0;
    mem_addr    = pc;
    unique case (state)
      IDLE: begin
        if (run) state_nxt = FETCH;
      end
      FETCH: begin
        mem_req = 1'b1;
        if (mem_ack) state_nxt = DECODE;
      end
      DECODE: begin
        if (len_eff == '0) state_nxt = EXEC;
        else               state_nxt = FETCH_EXT;
      end
      FETCH_EXT: begin
        mem_req = 1'b1;
        if (mem_ack && cnt == ONE_C) state_nxt = EXEC;
      end
      EXEC: begin
        phase       = 1'b1;
        instr_valid = 1'b1;
        if (exec_done) state_nxt = run ? FETCH : IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Program counter, instruction fields and extension bookkeeping.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc       <= '0;
      instr    <= '0;
      operand  <= '0;
      ext_data <= '0;
      cnt      <= '0;
      k        <= '0;
      len_err  <= 1'b0;
    end else begin
      unique case (state)
        FETCH: begin
          if (mem_ack) begin
            instr    <= mem_data[BYTE_W-1 -: OPC_W];
            operand  <= mem_data[OPR_W-1:0];
            ext_data <= '0;
            pc       <= pc + ADDR_W'(1);
          end
        end
        DECODE: begin
          cnt <= len_eff;
          k   <= '0;
          if (len_over) len_err <= 1'b1;
        end
        FETCH_EXT: begin
          if (mem_ack) begin
            for (int i = 0; i < MAX_EXT; i++) begin
              if (k == EXT_LEN_W'(i))
                ext_data[i*BYTE_W +: BYTE_W] <= mem_data;
            end
            pc  <= pc + ADDR_W'(1);
            k   <= k + ONE_C;
            cnt <= cnt - ONE_C;
          end
        end
        EXEC: begin
          if (exec_done && load_pc) pc <= new_addr;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer with a wait-state ROM model
// and a small opcode-to-length decode table.
module tb_fetch_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        run;
  logic [11:0] mem_addr;
  logic        mem_req;
  logic        mem_ack;
  logic [7:0]  mem_data;
  logic [3:0]  instr;
  logic [3:0]  operand;
  logic [15:0] ext_data;
  logic [1:0]  ext_len;
  logic        phase;
  logic        instr_valid;
  logic        exec_done;
  logic        load_pc;
  logic [11:0] new_addr;
  logic [11:0] pc;
  logic        len_err;

  logic [7:0]  rom [4096];
  int          waits;
  int          wcnt = 0;
  int          checks = 0;
  int          errors = 0;
  int          n;

  fetch_sequencer dut (
    .clk         (clk),
    .reset       (reset),
    .run         (run),
    .mem_addr    (mem_addr),
    .mem_req     (mem_req),
    .mem_ack     (mem_ack),
    .mem_data    (mem_data),
    .instr       (instr),
    .operand     (operand),
    .ext_data    (ext_data),
    .ext_len     (ext_len),
    .phase       (phase),
    .instr_valid (instr_valid),
    .exec_done   (exec_done),
    .load_pc     (load_pc),
    .new_addr    (new_addr),
    .pc          (pc),
    .len_err     (len_err)
  );

  always #5 clk = ~clk;

  // ROM: acks after `waits` stalled cycles of a request.
  always_comb begin
    mem_ack  = mem_req && (wcnt == waits);
    mem_data = rom[mem_addr];
  end

  always @(posedge clk) begin
    if (mem_req && !mem_ack) wcnt <= wcnt + 1;
    else                     wcnt <= 0;
  end

  // Opcode 9 carries two extension bytes, C claims three.
  always_comb begin
    ext_len = 2'd0;
    if (instr == 4'h9) ext_len = 2'd2;
    if (instr == 4'hC) ext_len = 2'd3;
  end

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int cyc);
    repeat (cyc) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset     = 1'b0;
    run       = 1'b0;
    exec_done = 1'b0;
    load_pc   = 1'b0;
    new_addr  = '0;
    waits     = 0;
    repeat (2) @(posedge clk);
    @(negedge clk) reset = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not terminate");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 4096; i++) rom[i] = 8'h00;
    rom[0]     = 8'h3A;
    rom[1]     = 8'h50;
    rom[2]     = 8'h51;
    rom[3]     = 8'h52;
    rom[4]     = 8'h53;
    rom[5]     = 8'h54;
    rom[10]    = 8'h9F;
    rom[11]    = 8'h12;
    rom[12]    = 8'h34;
    rom[12'h7F0] = 8'h40;
    rom[12'hFFF] = 8'h71;
    rom[12'h020] = 8'hC5;
    rom[12'h021] = 8'hAB;
    rom[12'h022] = 8'hCD;
    rom[12'h023] = 8'h60;

    do_reset();
    check("rst_req", mem_req, 0);
    check("rst_pc", pc, 0);
    check("rst_phase", phase, 0);
    check("rst_fields", {instr, operand, ext_data}, 0);

    // Zero-wait 1-byte instructions, exec_done tied high.
    run       = 1'b1;
    exec_done = 1'b1;
    step(1);
    check("a_req", mem_req, 1);
    check("a_addr", mem_addr, 0);
    step(1);
    check("a_dec_req", mem_req, 0);
    check("a_instr", instr, 4'h3);
    check("a_opnd", operand, 4'hA);
    check("a_dec_pc", pc, 1);
    check("a_dec_phase", phase, 0);
    step(1);
    check("a_phase", phase, 1);
    check("a_valid", instr_valid, 1);
    step(1);
    check("a_next_addr", mem_addr, 1);
    check("a_next_req", mem_req, 1);
    step(3);
    check("a_period", mem_addr, 2);
    step(9);
    check("a_at5", mem_addr, 5);
    check("a_at5_req", mem_req, 1);

    // Asynchronous reset mid-fetch.
    #2 reset = 1'b0;
    #1;
    check("ar_req", mem_req, 0);
    check("ar_pc", pc, 0);
    check("ar_fields", {instr, operand, ext_data, phase, len_err}, 0);
    repeat (2) @(posedge clk);
    @(negedge clk) reset = 1'b1;
    step(1);
    check("ar_resume_req", mem_req, 1);
    check("ar_resume_addr", mem_addr, 0);

    // Long execute with a branch to 0x7F0.
    do_reset();
    run = 1'b1;
    step(3);
    check("d_phase", phase, 1);
    load_pc  = 1'b1;
    new_addr = 12'h7F0;
    for (int c = 0; c < 4; c++) begin
      if (c == 3) exec_done = 1'b1;
      check("d_hold", {phase, instr, operand, ext_data}, 25'h13A0000);
      check("d_hold_pc", pc, 1);
      check("d_hold_req", mem_req, 0);
      step(1);
    end
    check("d_br_addr", mem_addr, 12'h7F0);
    check("d_br_req", mem_req, 1);
    new_addr = 12'd10;
    step(3);
    check("b_start", mem_addr, 10);

    // Three-byte instruction with two wait cycles per access.
    waits     = 2;
    exec_done = 1'b0;
    load_pc   = 1'b0;
    n = 0;
    while (!phase && n < 40) begin
      step(1);
      n++;
      if (n == 1) check("b_wait_stable", {mem_req, mem_addr}, 13'h100A);
    end
    check("b_latency", n, 10);
    check("b_ext", ext_data, 16'h3412);
    check("b_pc", pc, 13);
    check("b_instr", {instr, operand}, 8'h9F);

    // Branch to the top of memory; pc wraps after the fetch.
    waits     = 0;
    load_pc   = 1'b1;
    new_addr  = 12'hFFF;
    exec_done = 1'b1;
    step(1);
    check("w_addr", mem_addr, 12'hFFF);
    load_pc   = 1'b0;
    exec_done = 1'b0;
    step(1);
    check("w_pc", pc, 0);
    check("w_instr", {instr, operand}, 8'h71);
    step(1);
    check("w_phase", phase, 1);
    check("w_err", len_err, 0);

    // Over-long extension length is clamped and flagged.
    load_pc   = 1'b1;
    new_addr  = 12'h020;
    exec_done = 1'b1;
    step(1);
    check("l_addr", mem_addr, 12'h020);
    load_pc   = 1'b0;
    exec_done = 1'b0;
    step(1);
    check("l_dec_err", len_err, 0);
    step(1);
    check("l_ext1", {mem_req, mem_addr}, 13'h1021);
    check("l_err", len_err, 1);
    step(1);
    check("l_ext2", {mem_req, mem_addr}, 13'h1022);
    step(1);
    check("l_exec", {phase, mem_req}, 2'b10);
    check("l_data", ext_data, 16'hCDAB);
    check("l_pc", pc, 12'h023);

    // Stop after the next instruction completes.
    exec_done = 1'b1;
    step(1);
    check("s_fetch", mem_addr, 12'h023);
    run = 1'b0;
    step(1);
    check("s_dec", instr, 4'h6);
    step(1);
    check("s_exec", phase, 1);
    check("s_err_sticky", len_err, 1);
    step(1);
    check("s_idle", {phase, mem_req}, 2'b00);
    step(3);
    check("s_idle_hold", mem_req, 0);
    check("s_idle_pc", pc, 12'h024);

    do_reset();
    check("r_err_clr", len_err, 0);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
